// File: rtl/rr_mux2_arbiter_if.sv
// Handshake bundle for the round-robin mux front end: two producer streams in,
// one registered consumer stream out, plus the combinational mux select.
interface rr_mux2_arbiter_if #(
    parameter int WIDTH = 2
);
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic             sel;
    logic             z_valid;
    logic             z_ready;
    logic [WIDTH-1:0] z_data;
    logic             z_src;

    modport master (
        output a_valid, a_data, b_valid, b_data, z_ready,
        input  a_ready, b_ready, sel, z_valid, z_data, z_src
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, z_ready,
        output a_ready, b_ready, sel, z_valid, z_data, z_src
    );
endinterface

// File: rtl/rr_mux2_arbiter.sv
// Two small FIFOs (A, B) feeding a round-robin grant into a registered
// valid/ready output stage; sel is the live grant for the downstream mux.
module rr_mux2_arbiter #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux2_arbiter_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem  [2][DEPTH];
    logic [PW-1:0]    r_wptr [2];
    logic [PW-1:0]    r_rptr [2];
    logic [CW-1:0]    r_cnt  [2];
    logic             r_last;
    logic             r_z_valid;
    logic [WIDTH-1:0] r_z_data;
    logic             r_z_src;

    logic [WIDTH-1:0] w_in_data [2];
    logic [WIDTH-1:0] w_head    [2];
    logic [1:0]       w_in_valid;
    logic [1:0]       w_ready;
    logic [1:0]       w_ne;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic             w_load;
    logic             w_gnt;
    logic             w_gnt_vld;

    assign w_in_data[0] = bus.a_data;
    assign w_in_data[1] = bus.b_data;
    assign w_in_valid   = {bus.b_valid, bus.a_valid};

    // Ready looks only at occupancy, so a full FIFO refuses a push even while it pops.
    always_comb begin
        w_ready = '0;
        w_ne    = '0;
        for (int i = 0; i < 2; i++) begin
            w_ready[i] = (r_cnt[i] != CW'(DEPTH));
            w_ne[i]    = (r_cnt[i] != '0);
            w_head[i]  = r_mem[i][r_rptr[i]];
        end
    end

    assign w_push = w_in_valid & w_ready;
    assign w_load = ~r_z_valid | bus.z_ready;

    always_comb begin
        w_gnt = r_last;
        if (w_ne[0] && w_ne[1])
            w_gnt = ~r_last;
        else if (w_ne[0])
            w_gnt = 1'b0;
        else if (w_ne[1])
            w_gnt = 1'b1;
    end

    assign w_gnt_vld = w_load & (|w_ne);
    assign w_pop     = w_gnt_vld ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i])
                r_mem[i][r_wptr[i]] <= w_in_data[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i])
                    r_wptr[i] <= (r_wptr[i] == PW'(DEPTH - 1)) ? '0 : r_wptr[i] + 1'b1;
                if (w_pop[i])
                    r_rptr[i] <= (r_rptr[i] == PW'(DEPTH - 1)) ? '0 : r_rptr[i] + 1'b1;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // last resets to B so that A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z_valid <= 1'b0;
            r_z_data  <= '0;
            r_z_src   <= 1'b0;
            r_last    <= 1'b1;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_z_valid <= 1'b1;
                r_z_data  <= w_head[w_gnt];
                r_z_src   <= w_gnt;
                r_last    <= w_gnt;
            end else begin
                r_z_valid <= 1'b0;
            end
        end
    end

    assign bus.a_ready = w_ready[0];
    assign bus.b_ready = w_ready[1];
    assign bus.sel     = w_gnt;
    assign bus.z_valid = r_z_valid;
    assign bus.z_data  = r_z_data;
    assign bus.z_src   = r_z_src;
endmodule
